// File: rtl/npu_pkg.sv
// Shared NPU definitions: FSM state encoding, default widths and read-path helpers.
package npu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_LEN_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when one more word can be requested without overflowing a 2-entry buffer,
    // counting the word already on its way and the word leaving this cycle.
    function automatic logic buf_has_room(input logic [1:0] cnt, input logic inflight,
                                          input logic pop);
        logic [2:0] occ;
        occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer. Head entry drives the stream; a simultaneous write and
// pop keeps the count unchanged.
module skid_buffer2 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_cnt
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_cnt;
    logic                  w_pop;
    logic                  w_wr;

    // A pop of an empty buffer or a write into a full, non-draining one is dropped.
    assign w_pop = i_pop & (r_cnt != 2'd0);
    assign w_wr  = i_wr_en & ((r_cnt != 2'd2) | w_pop);

    // Storage and occupancy update; the tail slides into the head on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            unique case (r_cnt)
                2'd0: begin
                    if (w_wr) begin
                        r_head <= i_wr_data;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_wr && w_pop) begin
                        r_head <= i_wr_data;
                    end else if (w_wr) begin
                        r_tail <= i_wr_data;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_wr) begin
                            r_tail <= i_wr_data;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: drains burst_len words from a FIFO with 1-cycle read latency and
// presents them as a valid/ready stream with last-word marking.
module fifo_burst_reader
    import npu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LEN_W      = DEFAULT_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic [LEN_W-1:0] r_delivered;
    logic             r_inflight;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_buf_cnt;
    logic             w_buf_valid;
    logic             w_pop;
    logic             w_rd_en;
    logic             w_is_last;

    // Under enable=0 the head is still shown but never consumed.
    assign w_pop     = w_buf_valid & m_ready & enable;
    assign w_is_last = (r_delivered == (r_len - LEN_W'(1)));

    // Read strobe: never on an empty FIFO, never past len, never beyond buffer space.
    assign w_rd_en = (r_state == ST_RUN) & enable & ~fifo_empty & (r_issued < r_len)
                   & buf_has_room(w_buf_cnt, r_inflight, w_pop);

    // Tracks the word returning from the FIFO next cycle; captured even under enable=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    skid_buffer2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_inflight),
        .i_wr_data (fifo_data),
        .i_pop     (w_pop),
        .o_valid   (w_buf_valid),
        .o_data    (m_data),
        .o_cnt     (w_buf_cnt)
    );

    // Burst FSM with counters and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start && enable) begin
                        r_len       <= burst_len;
                        r_issued    <= '0;
                        r_delivered <= '0;
                        if (burst_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + LEN_W'(1);
                    end
                    if (w_pop) begin
                        r_delivered <= r_delivered + LEN_W'(1);
                        if (w_is_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (enable) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_buf_valid;
    assign m_last     = w_buf_valid & w_is_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed + randomized bench for fifo_burst_reader with a behavioural FIFO and a
// push-order scoreboard for the output stream.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];     // words currently held by the FIFO
    logic [DW-1:0] exp_q[$];  // words the stream must still deliver, in push order

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Sample the read strobe, cross the rising edge, then present the read data.
    task automatic edge_step();
        logic rd;
        rd = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && fq.size() != 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // rmode: 0 ready=1, 1 random ready, 2 ready low for the first 'hold' cycles.
    task automatic run_burst(input int len, input int rmode, input int hold, input int late_at,
                             input int late_n, input int restart_at, input int en_off_at,
                             input int en_off_len, input int abort_at, input int exp_done_c);
        int            rd_total = 0;
        int            del_total = 0;
        int            done_c = -1;
        logic          exp_done = 1'b0;
        logic          exp_done_next;
        logic          finished = 1'b0;
        logic          aborted = 1'b0;
        logic          prev_hold = 1'b0;
        logic          hs;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] w;

        @(negedge clk);
        chk("pre_busy", busy, 0);
        chk("pre_valid", m_valid, 0);
        start     = 1'b1;
        burst_len = LW'(len);
        enable    = 1'b1;
        m_ready   = (rmode != 2);
        #1;
        edge_step();
        exp_done_next = (len == 0);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start     = (c == restart_at);
            burst_len = (c == restart_at) ? LW'(9) : LW'(len);
            enable    = !(en_off_at >= 0 && c >= en_off_at && c < en_off_at + en_off_len);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = (c >= hold);
            endcase
            if (c == late_at) begin
                for (int k = 0; k < late_n; k++) push_word(DW'($urandom));
            end
            #1;
            if (c == abort_at) begin
                aborted = 1'b1;
                break;
            end
            exp_done      = exp_done_next;
            exp_done_next = 1'b0;

            chk("done", done, exp_done);
            chk("busy", busy, (len != 0) && !exp_done);
            if (c == 0) chk("first_valid", m_valid, 0);
            if (len == 0) chk("zero_valid", m_valid, 0);
            chk("rd_empty", fifo_rd_en & fifo_empty, 0);
            chk("rd_disabled", fifo_rd_en & ~enable, 0);
            chk("last_novalid", m_last & ~m_valid, 0);
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid) chk("last", m_last, (del_total == len - 1));

            if (fifo_rd_en) rd_total++;
            chk("rd_over", (rd_total <= len), 1);
            hs = m_valid & m_ready & enable;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("data", m_data, w);
                end
                del_total++;
                if (del_total == len) exp_done_next = 1'b1;
            end
            chk("outstanding", ((rd_total - del_total) <= 2), 1);
            prev_hold = m_valid & ~(m_ready & enable);
            prev_data = m_data;

            if (exp_done) begin
                done_c   = c;
                finished = 1'b1;
            end
            edge_step();
            if (finished) break;
        end

        if (!aborted) begin
            chk("finished", finished, 1);
            chk("delivered", del_total, len);
            chk("rd_count", rd_total, len);
            if (exp_done_c >= 0) chk("done_cycle", done_c, exp_done_c);
            @(negedge clk);
            start  = 1'b0;
            enable = 1'b1;
            #1;
            chk("done_pulse", done, 0);
            chk("busy_after", busy, 0);
            chk("valid_after", m_valid, 0);
            edge_step();
        end
    endtask

    initial begin
        int len;
        int pre;

        rst_n      = 1'b0;
        enable     = 1'b1;
        start      = 1'b0;
        burst_len  = '0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        m_ready    = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: three preloaded words at full rate.
        push_word(8'hA1);
        push_word(8'hB2);
        push_word(8'hC3);
        run_burst(3, 0, 0, -1, 0, -1, -1, 0, -1, 5);

        // Backpressure: ready low for five cycles.
        push_word(8'hD4);
        push_word(8'hE5);
        push_word(8'hF6);
        push_word(8'h07);
        run_burst(4, 2, 5, -1, 0, -1, -1, 0, -1, 9);

        // FIFO runs dry after two words; two more arrive six cycles in.
        push_word(8'h11);
        push_word(8'h22);
        run_burst(4, 0, 0, 6, 2, -1, -1, 0, -1, 10);

        // Zero length.
        run_burst(0, 0, 0, -1, 0, -1, -1, 0, -1, 0);

        // Start of length 9 while busy must be ignored.
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        run_burst(3, 0, 0, -1, 0, 2, -1, 0, -1, 5);

        // Enable dropped mid-burst with random ready.
        for (int k = 0; k < 5; k++) push_word(DW'($urandom));
        run_burst(5, 1, 0, -1, 0, -1, 3, 4, -1, -1);

        // Randomized bursts with partially late data.
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 12);
            pre = $urandom_range(0, len);
            for (int k = 0; k < pre; k++) push_word(DW'($urandom));
            run_burst(len, 1, 0, $urandom_range(0, 8), len - pre, -1, -1, 0, -1, -1);
        end

        // Asynchronous reset in the middle of a burst of 5.
        for (int k = 0; k < 5; k++) push_word(DW'($urandom));
        run_burst(5, 0, 0, -1, 0, -1, -1, 0, 3, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        edge_step();
        @(negedge clk);
        rst_n = 1'b1;
        push_word(8'h5A);
        push_word(8'hA5);
        run_burst(2, 0, 0, -1, 0, -1, -1, 0, -1, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
